// File: rtl/bf_io_if.sv
// Core / stream-side signal bundle for bf_io: the core I/O port, the TX and RX
// byte streams, and the status outputs.
interface bf_io_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  io_wr;
  logic [DATA_WIDTH-1:0] io_dout;
  logic                  io_rd;
  logic [DATA_WIDTH-1:0] io_din;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DEPTH_LOG2:0]   tx_count;
  logic [DEPTH_LOG2:0]   rx_count;
  logic                  tx_overflow;
  logic                  rx_underflow;
  logic                  clr_flags;

  modport master (
    output io_wr, io_dout, io_rd, tx_ready, rx_data, rx_valid, clr_flags,
    input  io_din, tx_data, tx_valid, rx_ready, tx_count, rx_count,
           tx_overflow, rx_underflow
  );

  modport slave (
    input  io_wr, io_dout, io_rd, tx_ready, rx_data, rx_valid, clr_flags,
    output io_din, tx_data, tx_valid, rx_ready, tx_count, rx_count,
           tx_overflow, rx_underflow
  );
endinterface

// File: rtl/bf_io.sv
// Byte-stream I/O stage: TX FIFO fed by the core, RX FIFO read by the core, sticky
// overflow/underflow flags. Define BF_IO_ECHO_EN to loop popped RX bytes back into TX.
module bf_io #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic    clk,
  input  logic    resetq,
  bf_io_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef logic [DEPTH_LOG2:0] ptr_t;

  logic [DATA_WIDTH-1:0] tx_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [DEPTH];

  ptr_t tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  ptr_t rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic run_q;

  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  rx_ready_w;
  logic                  tx_pop, tx_req, tx_push, tx_drop, echo_lost;
  logic                  rx_push, rx_pop, rx_unf;
  logic [DATA_WIDTH-1:0] tx_wdata, rx_head;

  assign tx_empty = (tx_wptr_q == tx_rptr_q);
  assign tx_full  = (tx_wptr_q[DEPTH_LOG2] != tx_rptr_q[DEPTH_LOG2]) &&
                    (tx_wptr_q[DEPTH_LOG2-1:0] == tx_rptr_q[DEPTH_LOG2-1:0]);
  assign rx_empty = (rx_wptr_q == rx_rptr_q);
  assign rx_full  = (rx_wptr_q[DEPTH_LOG2] != rx_rptr_q[DEPTH_LOG2]) &&
                    (rx_wptr_q[DEPTH_LOG2-1:0] == rx_rptr_q[DEPTH_LOG2-1:0]);

  // run_q keeps rx_ready low until the first clock after reset release
  assign rx_ready_w = run_q & ~rx_full;
  assign rx_head    = rx_mem_q[rx_rptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    tx_pop  = ~tx_empty & bus.tx_ready;
    rx_pop  = bus.io_rd & ~rx_empty;
    rx_unf  = bus.io_rd & rx_empty;
    rx_push = bus.rx_valid & rx_ready_w;
`ifdef BF_IO_ECHO_EN
    // io_wr owns the TX write port; a coinciding echo is lost and counts as overflow
    tx_req    = bus.io_wr | rx_pop;
    tx_wdata  = bus.io_wr ? bus.io_dout : rx_head;
    echo_lost = bus.io_wr & rx_pop;
`else
    tx_req    = bus.io_wr;
    tx_wdata  = bus.io_dout;
    echo_lost = 1'b0;
`endif
    tx_push = tx_req & (~tx_full | tx_pop);
    tx_drop = (tx_req & ~tx_push) | echo_lost;

    tx_wptr_d = tx_wptr_q + ptr_t'(tx_push);
    tx_rptr_d = tx_rptr_q + ptr_t'(tx_pop);
    rx_wptr_d = rx_wptr_q + ptr_t'(rx_push);
    rx_rptr_d = rx_rptr_q + ptr_t'(rx_pop);

    // a new event outranks a clear in the same cycle
    tx_ovf_d = tx_drop | (tx_ovf_q & ~bus.clr_flags);
    rx_unf_d = rx_unf  | (rx_unf_q & ~bus.clr_flags);
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_unf_q  <= rx_unf_d;
      run_q     <= 1'b1;
    end
  end

  // Storage needs no reset: entries are only observable between the pointers
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q[DEPTH_LOG2-1:0]] <= tx_wdata;
    if (rx_push) rx_mem_q[rx_wptr_q[DEPTH_LOG2-1:0]] <= bus.rx_data;
  end

  assign bus.io_din       = rx_empty ? '0 : rx_head;
  assign bus.tx_data      = tx_mem_q[tx_rptr_q[DEPTH_LOG2-1:0]];
  assign bus.tx_valid     = ~tx_empty;
  assign bus.rx_ready     = rx_ready_w;
  assign bus.tx_count     = tx_wptr_q - tx_rptr_q;
  assign bus.rx_count     = rx_wptr_q - rx_rptr_q;
  assign bus.tx_overflow  = tx_ovf_q;
  assign bus.rx_underflow = rx_unf_q;

endmodule

// File: tb/tb_bf_io.sv
// Directed bench for bf_io: TX ordering/overflow, full push-with-pop, RX backpressure,
// underflow and flag clear, asynchronous reset, and the optional echo path.
module tb_bf_io;

  logic clk = 1'b0;
  logic resetq;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  bf_io_if #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) bus ();

  bf_io #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
    .clk    (clk),
    .resetq (resetq),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetq        = 1'b0;
    bus.io_wr     = 1'b0;
    bus.io_dout   = '0;
    bus.io_rd     = 1'b0;
    bus.tx_ready  = 1'b0;
    bus.rx_data   = '0;
    bus.rx_valid  = 1'b0;
    bus.clr_flags = 1'b0;
    #3;
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_tx_count", bus.tx_count, 0);
    chk("rst_rx_count", bus.rx_count, 0);
    chk("rst_tx_ovf",   bus.tx_overflow, 0);
    chk("rst_rx_unf",   bus.rx_underflow, 0);
    chk("rst_io_din",   bus.io_din, 0);
    tick();
    tick();
    resetq = 1'b1;
    #1;
    tick();
    chk("post_rst_rx_ready", bus.rx_ready, 1);

    // Push order with a ready sink
    bus.tx_ready = 1'b1;
    bus.io_wr = 1'b1; bus.io_dout = 8'h41;
    tick();
    bus.io_dout = 8'h42; #1;
    chk("order_valid0", bus.tx_valid, 1);
    chk("order_data0", bus.tx_data, 8'h41);
    tick();
    bus.io_dout = 8'h43; #1;
    chk("order_data1", bus.tx_data, 8'h42);
    tick();
    bus.io_wr = 1'b0; #1;
    chk("order_data2", bus.tx_data, 8'h43);
    tick();
    chk("order_drained", bus.tx_valid, 0);

    // TX overflow: 17 writes into a stalled sink
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.io_wr = 1'b1; bus.io_dout = 8'(i);
      tick();
    end
    bus.io_wr = 1'b0; #1;
    chk("ovf_count", bus.tx_count, 16);
    chk("ovf_flag", bus.tx_overflow, 1);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("ovf_drain", bus.tx_data, i);
      tick();
    end
    bus.tx_ready = 1'b0; #1;
    chk("ovf_empty", bus.tx_valid, 0);
    chk("ovf_sticky", bus.tx_overflow, 1);
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0; #1;
    chk("ovf_cleared", bus.tx_overflow, 0);

    // Full FIFO: push coinciding with pop is accepted
    for (int i = 0; i < 16; i++) begin
      bus.io_wr = 1'b1; bus.io_dout = 8'(8'h80 + i);
      tick();
    end
    bus.io_dout = 8'h55; bus.tx_ready = 1'b1;
    tick();
    bus.io_wr = 1'b0; bus.tx_ready = 1'b0; #1;
    chk("fpp_no_ovf", bus.tx_overflow, 0);
    chk("fpp_count", bus.tx_count, 16);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("fpp_drain", bus.tx_data, (i < 15) ? (8'h81 + i) : 8'h55);
      tick();
    end
    bus.tx_ready = 1'b0; #1;
    chk("fpp_empty", bus.tx_valid, 0);

    // RX backpressure: the 17th byte is refused
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.rx_data = 8'(8'h10 + i);
      tick();
    end
    bus.rx_valid = 1'b0; #1;
    chk("rx_full_ready", bus.rx_ready, 0);
    chk("rx_full_count", bus.rx_count, 16);
    bus.io_rd = 1'b1; #1;
    chk("rx_read_head", bus.io_din, 8'h10);
    tick();
    bus.io_rd = 1'b0; #1;
    chk("rx_ready_again", bus.rx_ready, 1);
    chk("rx_count_15", bus.rx_count, 15);
    for (int i = 0; i < 15; i++) begin
      bus.io_rd = 1'b1; #1;
      chk("rx_drain", bus.io_din, 8'h11 + i);
      tick();
    end
    bus.io_rd = 1'b0; #1;
    chk("rx_empty_count", bus.rx_count, 0);
    chk("rx_no_unf", bus.rx_underflow, 0);

    // Underflow, set-over-clear priority, then clear
    bus.io_rd = 1'b1; #1;
    chk("unf_din", bus.io_din, 0);
    tick();
    bus.io_rd = 1'b0; #1;
    chk("unf_flag", bus.rx_underflow, 1);
    chk("unf_ptrs", bus.rx_count, 0);
    bus.io_rd = 1'b1; bus.clr_flags = 1'b1;
    tick();
    bus.io_rd = 1'b0; #1;
    chk("unf_set_wins", bus.rx_underflow, 1);
    tick();
    bus.clr_flags = 1'b0; #1;
    chk("unf_cleared", bus.rx_underflow, 0);

    // Asynchronous reset mid-stream
    bus.io_wr = 1'b1; bus.io_dout = 8'hA5;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    tick();
    tick();
    tick();
    bus.io_wr = 1'b0; bus.rx_valid = 1'b0; #1;
    chk("pre_arst_tx_count", bus.tx_count, 3);
    chk("pre_arst_rx_count", bus.rx_count, 3);
    #1;
    resetq = 1'b0; #1;
    chk("arst_tx_count", bus.tx_count, 0);
    chk("arst_rx_count", bus.rx_count, 0);
    chk("arst_tx_valid", bus.tx_valid, 0);
    chk("arst_rx_ready", bus.rx_ready, 0);
    chk("arst_io_din", bus.io_din, 0);
    tick();
    resetq = 1'b1;
    tick();
    chk("arst_release_ready", bus.rx_ready, 1);

    // Echo of a popped RX byte (only present when the feature is built in)
    bus.rx_valid = 1'b1; bus.rx_data = 8'h61;
    tick();
    bus.rx_valid = 1'b0;
    bus.io_rd = 1'b1; #1;
    chk("echo_din", bus.io_din, 8'h61);
    tick();
    bus.io_rd = 1'b0; #1;
    chk("echo_rx_count", bus.rx_count, 0);
`ifdef BF_IO_ECHO_EN
    chk("echo_tx_valid", bus.tx_valid, 1);
    chk("echo_tx_data", bus.tx_data, 8'h61);
`else
    chk("no_echo_tx_valid", bus.tx_valid, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
